// File: rtl/spi_cmd_handler_pkg.sv
// Shared opcodes, FSM state encoding and default response bytes for the SPI command layer.
package spi_cmd_pkg;

  localparam logic [7:0] OP_GET_STATE = 8'hFF;
  localparam logic [7:0] OP_WRITE_REG = 8'h01;
  localparam logic [7:0] OP_READ_REG  = 8'h02;
  localparam logic [7:0] OP_GET_CNT   = 8'h03;

  localparam logic [7:0] ACK_BYTE_DEF = 8'hA5;
  localparam logic [7:0] ERR_BYTE_DEF = 8'hEE;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_RESP      = 2'd2
  } state_t;

endpackage

// File: rtl/spi_cmd_handler_if.sv
// Byte-level handshake between the SPI slave (master side here) and the command handler.
interface spi_cmd_handler_if;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic       o_TX_DV;
  logic [7:0] o_TX_Byte;

  modport slave  (input  i_RX_DV, i_RX_Byte, output o_TX_DV, o_TX_Byte);
  modport master (output i_RX_DV, i_RX_Byte, input  o_TX_DV, o_TX_Byte);
endinterface

// File: rtl/spi_cmd_handler.sv
// Decodes SPI command bytes and loads one response byte per command.
// Optional WAIT_DATA timeout enabled by defining SPI_CMD_TIMEOUT_EN.
//   state        | meaning
//   ST_IDLE      | waiting for an opcode byte
//   ST_WAIT_DATA | WRITE_REG seen, waiting for its data byte
//   ST_RESP      | response loaded this cycle; extra RX bytes are dropped
module spi_cmd_handler
  import spi_cmd_pkg::*;
#(
  parameter logic [7:0] ACK_BYTE = ACK_BYTE_DEF,
  parameter logic [7:0] ERR_BYTE = ERR_BYTE_DEF
`ifdef SPI_CMD_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  spi_cmd_handler_if.slave       bus,
  input  logic                   i_SPI_CS_n,
  input  logic [1:0]             i_Fsm_State,
  output logic [7:0]             o_Reg,
  output logic                   o_Cmd_Err
);

  state_t     state_q;
  logic       tx_dv_q;
  logic [7:0] tx_byte_q;
  logic [7:0] reg_q;
  logic       err_q;
  logic [7:0] cmd_cnt_q;

`ifdef SPI_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_cnt_q;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= ST_IDLE;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      reg_q     <= 8'h00;
      err_q     <= 1'b0;
      cmd_cnt_q <= 8'h00;
`ifdef SPI_CMD_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      tx_dv_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.i_RX_DV) begin
            state_q <= ST_RESP;
            unique case (bus.i_RX_Byte)
              OP_GET_STATE: begin
                tx_byte_q <= {6'b0, i_Fsm_State};
                tx_dv_q   <= 1'b1;
                cmd_cnt_q <= cmd_cnt_q + 8'd1;
              end
              OP_READ_REG: begin
                tx_byte_q <= reg_q;
                tx_dv_q   <= 1'b1;
                cmd_cnt_q <= cmd_cnt_q + 8'd1;
              end
              OP_GET_CNT: begin
                tx_byte_q <= cmd_cnt_q;
                tx_dv_q   <= 1'b1;
                cmd_cnt_q <= cmd_cnt_q + 8'd1;
              end
              OP_WRITE_REG: begin
                state_q <= ST_WAIT_DATA;
`ifdef SPI_CMD_TIMEOUT_EN
                tmo_cnt_q <= '0;
`endif
              end
              default: begin
                tx_byte_q <= ERR_BYTE;
                tx_dv_q   <= 1'b1;
                err_q     <= 1'b1;
              end
            endcase
          end
        end
        ST_WAIT_DATA: begin
          // Data beats both CS release and timeout when they coincide.
          if (bus.i_RX_DV) begin
            reg_q     <= bus.i_RX_Byte;
            tx_byte_q <= ACK_BYTE;
            tx_dv_q   <= 1'b1;
            cmd_cnt_q <= cmd_cnt_q + 8'd1;
            state_q   <= ST_RESP;
          end else if (i_SPI_CS_n) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
`ifdef SPI_CMD_TIMEOUT_EN
          else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
`endif
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          if (bus.i_RX_DV) err_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_TX_DV   = tx_dv_q;
  assign bus.o_TX_Byte = tx_byte_q;
  assign o_Reg         = reg_q;
  assign o_Cmd_Err     = err_q;

endmodule

// File: tb/tb_spi_cmd_handler.sv
// Directed bench for spi_cmd_handler: per-cycle model compare plus literal spot checks.
module tb_spi_cmd_handler;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs_n;
  logic [1:0] fsm;
  logic [7:0] reg_o;
  logic       err_o;

  int tests_run = 0;
  int tests_failed = 0;

  spi_cmd_handler_if bus ();

`ifdef SPI_CMD_TIMEOUT_EN
  spi_cmd_handler #(.TIMEOUT_CYCLES(TMO)) dut (
`else
  spi_cmd_handler dut (
`endif
    .i_Clk       (clk),
    .i_Rst       (rst),
    .bus         (bus.slave),
    .i_SPI_CS_n  (cs_n),
    .i_Fsm_State (fsm),
    .o_Reg       (reg_o),
    .o_Cmd_Err   (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: tracks "awaiting write data" and "just responded".
  logic       m_awaiting = 1'b0;
  logic       m_responded = 1'b0;
  logic [7:0] m_reg = 8'h00;
  logic [7:0] m_cnt = 8'h00;
  logic [7:0] m_tx = 8'h00;
  logic       m_dv = 1'b0;
  logic       m_err = 1'b0;
  int         m_waited = 0;

  always @(posedge clk) begin
    m_dv  <= 1'b0;
    m_err <= 1'b0;
    if (rst) begin
      m_awaiting  <= 1'b0;
      m_responded <= 1'b0;
      m_reg       <= 8'h00;
      m_cnt       <= 8'h00;
      m_tx        <= 8'h00;
    end else if (m_responded) begin
      m_responded <= 1'b0;
      if (bus.i_RX_DV) m_err <= 1'b1;
    end else if (m_awaiting) begin
      if (bus.i_RX_DV) begin
        m_reg <= bus.i_RX_Byte; m_tx <= 8'hA5; m_dv <= 1'b1;
        m_cnt <= m_cnt + 8'd1; m_awaiting <= 1'b0; m_responded <= 1'b1;
      end else if (cs_n) begin
        m_awaiting <= 1'b0; m_err <= 1'b1;
      end
`ifdef SPI_CMD_TIMEOUT_EN
      else if (m_waited + 1 >= TMO) begin
        m_awaiting <= 1'b0; m_err <= 1'b1;
      end else begin
        m_waited <= m_waited + 1;
      end
`endif
    end else if (bus.i_RX_DV) begin
      m_responded <= 1'b1;
      if (bus.i_RX_Byte == 8'hFF) begin
        m_tx <= {6'b0, fsm}; m_dv <= 1'b1; m_cnt <= m_cnt + 8'd1;
      end else if (bus.i_RX_Byte == 8'h02) begin
        m_tx <= m_reg; m_dv <= 1'b1; m_cnt <= m_cnt + 8'd1;
      end else if (bus.i_RX_Byte == 8'h03) begin
        m_tx <= m_cnt; m_dv <= 1'b1; m_cnt <= m_cnt + 8'd1;
      end else if (bus.i_RX_Byte == 8'h01) begin
        m_responded <= 1'b0; m_awaiting <= 1'b1; m_waited <= 0;
      end else begin
        m_tx <= 8'hEE; m_dv <= 1'b1; m_err <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_tx_dv",   {7'b0, bus.o_TX_DV}, {7'b0, m_dv});
    check("cyc_tx_byte", bus.o_TX_Byte, m_tx);
    check("cyc_reg",     reg_o, m_reg);
    check("cyc_err",     {7'b0, err_o}, {7'b0, m_err});
  end

  // Drive a byte for one cycle; returns just after the response cycle has been clocked.
  task automatic send(input logic [7:0] b);
    bus.i_RX_DV = 1'b1; bus.i_RX_Byte = b;
    @(negedge clk);
    bus.i_RX_DV = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_resp(input string nm, input logic [7:0] b, input logic e);
    check({nm, "_dv"},   {7'b0, bus.o_TX_DV}, 8'h01);
    check({nm, "_byte"}, bus.o_TX_Byte, b);
    check({nm, "_err"},  {7'b0, err_o}, {7'b0, e});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cs_n = 1'b0; fsm = 2'b10;
    bus.i_RX_DV = 1'b0; bus.i_RX_Byte = 8'h00;
    idle(2);
    check("rst_tx_byte", bus.o_TX_Byte, 8'h00);
    check("rst_reg", reg_o, 8'h00);
    check("rst_dv", {7'b0, bus.o_TX_DV}, 8'h00);
    rst = 1'b0;
    idle(1);

    send(8'hFF); expect_resp("get_state", 8'h02, 1'b0); idle(1);
    send(8'h03); expect_resp("cnt_after_1", 8'h01, 1'b0); idle(1);

    send(8'h01); check("wr_no_dv", {7'b0, bus.o_TX_DV}, 8'h00); idle(1);
    send(8'h5C); expect_resp("wr_ack", 8'hA5, 1'b0); check("wr_reg", reg_o, 8'h5C); idle(1);
    send(8'h02); expect_resp("read_reg", 8'h5C, 1'b0); idle(1);

    send(8'h01);
    cs_n = 1'b1; idle(1);
    check("abort_err", {7'b0, err_o}, 8'h01);
    check("abort_no_dv", {7'b0, bus.o_TX_DV}, 8'h00);
    check("abort_reg", reg_o, 8'h5C);
    cs_n = 1'b0;
    send(8'h03); expect_resp("cnt_after_abort", 8'h04, 1'b0); idle(1);

    send(8'h7E); expect_resp("unknown", 8'hEE, 1'b1); idle(1);
    send(8'h03); expect_resp("cnt_after_err", 8'h05, 1'b0); idle(1);

    for (int i = 0; i < 250; i++) begin
      fsm = 2'(i);
      send(8'hFF); idle(1);
    end
    send(8'h03); expect_resp("cnt_wrap", 8'h00, 1'b0); idle(1);
    fsm = 2'b01;
    send(8'hFF); expect_resp("get_state_01", 8'h01, 1'b0);
    send(8'h02);
    check("resp_drop_err", {7'b0, err_o}, 8'h01);
    check("resp_drop_no_dv", {7'b0, bus.o_TX_DV}, 8'h00);
    idle(1);
    send(8'h03); expect_resp("cnt_after_drop", 8'h02, 1'b0); idle(1);

    cs_n = 1'b1;
    send(8'h02); expect_resp("cs_ignored_idle", 8'h5C, 1'b0); idle(1);
    cs_n = 1'b0;
    send(8'h01); cs_n = 1'b1;
    send(8'h33); expect_resp("data_beats_cs", 8'hA5, 1'b0);
    check("data_beats_cs_reg", reg_o, 8'h33);
    cs_n = 1'b0; idle(1);

    send(8'h01);
    rst = 1'b1; idle(1); rst = 1'b0;
    check("midrst_reg", reg_o, 8'h00);
    check("midrst_tx", bus.o_TX_Byte, 8'h00);
    send(8'h44); expect_resp("after_rst", 8'hEE, 1'b1); idle(1);
    check("after_rst_reg", reg_o, 8'h00);

`ifdef SPI_CMD_TIMEOUT_EN
    send(8'h01);
    idle(TMO - 1);
    check("tmo_no_err_yet", {7'b0, err_o}, 8'h00);
    idle(1);
    check("tmo_err", {7'b0, err_o}, 8'h01);
    check("tmo_reg", reg_o, 8'h00);
    idle(1);
    send(8'h03); expect_resp("tmo_idle_cnt", 8'h00, 1'b0); idle(1);

    send(8'h01);
    idle(TMO - 1);
    send(8'h9A); expect_resp("tmo_edge_ack", 8'hA5, 1'b0);
    check("tmo_edge_reg", reg_o, 8'h9A);
    idle(2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_cmd_handler.md
Name: spi_cmd_handler

Overview:
- Command layer directly downstream of the SPI slave byte interface, on the slave's system clock.
- Consumes received bytes (RX valid + byte), decodes single- and two-byte commands, and loads exactly one response byte per command into the slave's TX path (TX valid pulse + byte).
- Exposes the game/lab FSM state, one writable 8-bit control register and a command counter to the SPI master.

Parameters:
- ACK_BYTE, 8'hA5, response to a completed WRITE_REG.
- ERR_BYTE, 8'hEE, response to an unknown opcode.
- TIMEOUT_CYCLES, 1024, WAIT_DATA timeout in i_Clk cycles; used only with SPI_CMD_TIMEOUT_EN.

Ports:
- i_Clk  in  1  system clock, same clock as the SPI slave.
- i_Rst  in  1  reset: one clock; reset is synchronous and active-high.
- i_RX_DV  in  1  one-cycle pulse; i_RX_Byte is valid in that cycle.
- i_RX_Byte  in  8  received byte.
- i_SPI_CS_n  in  1  chip select, active low, already synchronised to i_Clk.
- i_Fsm_State  in  2  current FSM state.
- o_TX_DV  out  1  one-cycle pulse; the slave latches o_TX_Byte in that cycle.
- o_TX_Byte  out  8  response byte; holds its value until the next load.
- o_Reg  out  8  control register written by WRITE_REG.
- o_Cmd_Err  out  1  one-cycle pulse on any protocol error.

Behaviour:
- Reset values: o_TX_DV=0, o_TX_Byte=8'h00, o_Reg=8'h00, o_Cmd_Err=0, cmd_cnt=8'h00, state=IDLE. Reset has priority over all events, including mid-transaction (a pending WRITE_REG is discarded).
- Opcodes:
  - 8'hFF GET_STATE
  - 8'h01 WRITE_REG
  - 8'h02 READ_REG
  - 8'h03 GET_CNT
- States: IDLE, WAIT_DATA, RESP.
- IDLE, on i_RX_DV in cycle N:
  - GET_STATE: load {6'b0, i_Fsm_State sampled in cycle N}; cmd_cnt+1; go to RESP.
  - READ_REG: load o_Reg; cmd_cnt+1; go to RESP.
  - GET_CNT: load cmd_cnt value before the increment; cmd_cnt+1; go to RESP.
  - WRITE_REG: go to WAIT_DATA; no TX load; cmd_cnt unchanged until the data byte arrives.
  - Other opcodes: load ERR_BYTE; o_Cmd_Err=1 in cycle N+1; cmd_cnt unchanged; go to RESP.
- Response latency: o_TX_DV is high in cycle N+1 only, with o_TX_Byte already valid in that cycle.
- RESP: lasts one cycle, then IDLE. An i_RX_DV arriving in RESP is dropped and o_Cmd_Err pulses one cycle later.
- WAIT_DATA:
  - On i_RX_DV: o_Reg <= byte; load ACK_BYTE; cmd_cnt+1; go to RESP.
  - Else, if i_SPI_CS_n=1: abort to IDLE; o_Reg unchanged; o_Cmd_Err pulses; no TX load.
  - i_RX_DV and CS_n high in the same cycle: the data write wins.
- cmd_cnt: 8-bit, wraps 8'hFF -> 8'h00.
- i_SPI_CS_n is ignored in IDLE and RESP.

Optional Feature:
- Macro SPI_CMD_TIMEOUT_EN.
- Defined: a counter clears on entry to WAIT_DATA and increments each cycle spent there. After TIMEOUT_CYCLES cycles without i_RX_DV, the block returns to IDLE, o_Reg is unchanged and o_Cmd_Err pulses. An i_RX_DV in the expiry cycle wins over the timeout.
- Undefined: no counter; WAIT_DATA exits only on data, CS abort or reset.

Decomposition:
- Package spi_cmd_pkg holds: opcode constants; the state encoding (IDLE/WAIT_DATA/RESP); default ACK/ERR byte values.
- No sub-module. Decode plus FSM is one process; the timeout counter stays inline under the macro.

Test Plan:
- Reset, i_Fsm_State=2'b10, RX 8'hFF -> o_TX_DV pulse 1 cycle later, o_TX_Byte=8'h02, cmd_cnt=1.
- RX 8'h01 then RX 8'h5C -> o_Reg=8'h5C; TX 8'hA5; following RX 8'h02 -> TX 8'h5C.
- RX 8'h01, then CS_n=1 before data -> o_Cmd_Err pulse, o_Reg unchanged, no o_TX_DV; next RX 8'h03 -> TX count excluding aborted write.
- RX 8'h7E -> TX 8'hEE, o_Cmd_Err pulse, cmd_cnt unchanged; 256 valid commands -> GET_CNT returns wrapped value.
- Assert i_Rst in WAIT_DATA, then RX 8'h44 -> treated as unknown opcode (TX 8'hEE); o_Reg=8'h00.
- With SPI_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16: RX 8'h01, idle 16 cycles -> o_Cmd_Err, state IDLE; RX_DV on the expiry cycle -> write accepted.
